// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner : N-channel button synchroniser, debouncer and edge pulser.
// Optional auto-repeat on held buttons via macro BTN_AUTOREPEAT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_conditioner #(
   parameter int NUM_BTN       = 3,
   parameter int DEBOUNCE_BITS = 18,
   parameter int REPEAT_DELAY  = 8000000,
   parameter int REPEAT_PERIOD = 2000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release
);

   logic [NUM_BTN-1:0]       sync1_q, sync1_d;
   logic [NUM_BTN-1:0]       sync2_q, sync2_d;
   logic [NUM_BTN-1:0]       level_q, level_d;
   logic [NUM_BTN-1:0]       press_q, press_d;
   logic [NUM_BTN-1:0]       release_q, release_d;
   logic [DEBOUNCE_BITS-1:0] cnt_q [NUM_BTN];
   logic [DEBOUNCE_BITS-1:0] cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0]       commit;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [23:0] RPT_LAST   = 24'(REPEAT_DELAY - 1);
   localparam logic [23:0] RPT_RELOAD = 24'(REPEAT_DELAY - REPEAT_PERIOD);

   logic [23:0] rc_q [NUM_BTN];
   logic [23:0] rc_d [NUM_BTN];
`else
   logic unused_rpt_params;
   assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

   always_comb begin
      sync1_d   = btn_raw;
      sync2_d   = sync1_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      commit    = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            // A saturated counter always commits, so it can never wrap.
            if (&cnt_q[i]) begin
               commit[i]    = 1'b1;
               level_d[i]   = sync2_q[i];
               press_d[i]   = ena & sync2_q[i];
               release_d[i] = ena & ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
`ifdef BTN_AUTOREPEAT_EN
         // Release commits take precedence so press and release never coincide.
         rc_d[i] = '0;
         if (level_q[i] && !commit[i]) begin
            if (rc_q[i] == RPT_LAST) begin
               press_d[i] = ena;
               rc_d[i]    = RPT_RELOAD;
            end else begin
               rc_d[i] = rc_q[i] + 1'b1;
            end
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            cnt_q[i] <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rc_q[i]  <= '0;
`endif
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < NUM_BTN; i++) begin
            cnt_q[i] <= cnt_d[i];
`ifdef BTN_AUTOREPEAT_EN
            rc_q[i]  <= rc_d[i];
`endif
         end
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

`default_nettype wire
